mvau_weight_stream: RTL
=======================

# mvau_weight_stream

Weight-stream source for `mvau_stream`. It holds the layer's weight matrix in PE on-chip banks and replays it as a valid/ready stream of PE×SIMD weight words. The order matches the MVAU's consumption: for every input vector, every neuron fold, then every synapse fold. It sits directly upstream of the `in_wgt` port of `mvau_stream`, alongside the activation stream.

## Interface
- `SIMD`, 2: weights per PE per beat
- `PE`, 2: processing elements (output lanes)
- `TW`, 4: weight word length
- `MatrixW`, 4: weight matrix width; must be a multiple of SIMD
- `MatrixH`, 4: weight matrix height; must be a multiple of PE
- `NUM_VEC`, 3: input vectors per run (OFMDim×OFMDim)
- `WMEM_DEPTH`, (MatrixW/SIMD)×(MatrixH/PE): words per bank; derived, do not override
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request to begin a run
- `wr_en`  in  1  weight-memory write strobe
- `wr_pe`  in  max(1,$clog2(PE))  target bank
- `wr_addr`  in  $clog2(WMEM_DEPTH)  word address, nf×(MatrixW/SIMD)+sf
- `wr_data`  in  SIMD×TW  SIMD weights; element 0 in the most significant TW bits
- `out_v`  out  1  output word valid
- `out_rdy`  in  1  downstream ready
- `out_wgt`  out  PE×SIMD×TW  PE lane 0 is the most significant SIMD×TW slice; within a lane, element 0 is most significant (matches `in_wgt` ordering)
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse with the final accepted beat
- `wr_err`  out  1  sticky write-guard flag (see Configuration)

## Operation
- **Storage:** PE banks, each WMEM_DEPTH × SIMD×TW. Writes are synchronous. Reads are synchronous with 1-cycle latency. All banks are read at one common address per beat.
- **FSM:**
  - IDLE→RUN when `start` is high.
  - RUN→IDLE after the last beat is accepted.
  - `start` is ignored in RUN.
- **Counters:**
  - sf: 0..MatrixW/SIMD−1, innermost.
  - nf: 0..MatrixH/PE−1.
  - vec: 0..NUM_VEC−1, outermost.
  - Read address = nf×(MatrixW/SIMD)+sf. It wraps to 0 at each new vec.
  - Total beats = NUM_VEC×WMEM_DEPTH.
- **Issue:**
  - A read is issued when the 2-entry skid buffer plus the in-flight read cannot overflow, i.e. occupancy + in-flight ≤ 1 after this cycle's pop.
  - The counters advance only on an issue.
  - Issues stop once all beats have been issued.
- **Handshake:**
  - A beat transfers when `out_v` and `out_rdy` are both high.
  - `out_wgt` is stable while `out_v` is high and `out_rdy` is low.
  - `out_v` never drops without a transfer.
  - No beat is dropped or duplicated.
- **Completion:** `done` pulses in the same cycle as the final transfer. `busy` falls on the next edge.
- **Reset (asynchronous):**
  - `out_v`=0, `out_wgt`=0, `busy`=0, `done`=0, `wr_err`=0.
  - FSM goes to IDLE; counters and skid buffer are cleared.
  - Bank contents are not reset.
  - Reset asserted mid-run abandons the run; no `done` is produced.

## Timing
- `start` sampled at edge E0: `busy`=1 after E0; address 0 issued at E0; `out_v`=1 after E0+2 (2-cycle first-beat latency).
- With `out_rdy` held high: 1 beat per cycle. The last beat is at E0+1+NUM_VEC×WMEM_DEPTH.
- `out_rdy` low for N cycles: the stream pauses N cycles; no bubble is inserted after `out_rdy` returns (the skid buffer covers the in-flight read).
- A write and a read to the same bank/address in the same cycle: the read returns the old data.
- `start` asserted in the cycle `done` pulses: ignored. A new `start` is accepted only once `busy`=0.

## Configuration
- `MVAU_WSTREAM_WR_GUARD_EN` defined:
  - Writes with `wr_en` while `busy`=1 are dropped.
  - `wr_err` is set and stays set until reset.
- `MVAU_WSTREAM_WR_GUARD_EN` undefined:
  - Writes are always performed; `wr_err` is tied to 0.
  - Writing during a run produces a mixed stream; this is the user's responsibility.

## Test plan
- Defaults; load bank b, addr a with {b,a,b,a} nibbles; `start`; `out_rdy`=1 → 12 beats in order addr 0,1,2,3,0,1,2,3,0,1,2,3; lane0 = bank0 word; first `out_v` 2 cycles after `start`; `done` with beat 12.
- Random `out_rdy` (50%) over the same run → the sequence is identical to the first scenario, `out_wgt` is stable during stalls, and exactly 12 transfers occur.
- `out_rdy`=0 from the first `out_v` for 5 cycles, then 1 → beat 0 is held 5 cycles, then beats 1..11 follow back-to-back.
- `rst` pulsed after beat 5 → all outputs go to 0 immediately, no `done`; a new `start` replays from addr 0 with the weights intact.
- `start` while `busy`, and `start` in the `done` cycle → both ignored; the beat count stays 12.
- Guard: with the macro defined, `wr_en` during a run → data unchanged and `wr_err`=1; with the macro undefined → the written word appears in subsequent beats and `wr_err`=0.

Source files
------------

// File: rtl/mvau_weight_stream.sv
// ---------------------------------------------------------------------------
// mvau_weight_stream
//
// Weight-stream source for mvau_stream. PE on-chip banks hold the weight
// matrix. On each run the banks are replayed as PE x SIMD weight words in
// MVAU consumption order: for every input vector, every neuron fold, then
// every synapse fold. Reads are registered (1-cycle latency). A 2-entry skid
// buffer holds the read data so that a downstream stall never drops or
// duplicates a beat, and so that no bubble appears when ready returns.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle run request (ignored while busy)
//   wr_en/wr_pe/    weight-memory write: bank, word address nf*SF+sf,
//   wr_addr/wr_data SIMD weights (element 0 in the most significant TW bits)
//   out_v/out_rdy   valid/ready handshake of the weight stream
//   out_wgt         PE x SIMD x TW word, lane 0 in the most significant slice
//   busy            run in progress
//   done            pulse coincident with the final accepted beat
//   wr_err          sticky flag: write attempted during a run (guard build)
//
// Build option:
//   MVAU_WSTREAM_WR_GUARD_EN  when defined, writes during a run are dropped
//                             and wr_err is set; otherwise writes always land
//                             and wr_err is tied low.
// ---------------------------------------------------------------------------
module mvau_weight_stream #(
    parameter int SIMD       = 2,
    parameter int PE         = 2,
    parameter int TW         = 4,
    parameter int MatrixW    = 4,
    parameter int MatrixH    = 4,
    parameter int NUM_VEC    = 3,
    parameter int WMEM_DEPTH = (MatrixW / SIMD) * (MatrixH / PE)
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  start,
    input  logic                                                  wr_en,
    input  logic [((PE > 1) ? $clog2(PE) : 1)-1:0]                wr_pe,
    input  logic [((WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1)-1:0] wr_addr,
    input  logic [SIMD*TW-1:0]                                    wr_data,
    output logic                                                  out_v,
    input  logic                                                  out_rdy,
    output logic [PE*SIMD*TW-1:0]                                 out_wgt,
    output logic                                                  busy,
    output logic                                                  done,
    output logic                                                  wr_err
);
    localparam int SF    = MatrixW / SIMD;
    localparam int NF    = MatrixH / PE;
    localparam int AW    = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1;
    localparam int SFW   = (SF > 1) ? $clog2(SF) : 1;
    localparam int NFW   = (NF > 1) ? $clog2(NF) : 1;
    localparam int VW    = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
    localparam int TOTAL = NUM_VEC * WMEM_DEPTH;
    localparam int TCW   = $clog2(TOTAL + 1);
    localparam int LW    = SIMD * TW;
    localparam int OW    = PE * LW;

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    logic [SFW-1:0]   sf_q, sf_d;
    logic [NFW-1:0]   nf_q, nf_d;
    logic [VW-1:0]    vec_q, vec_d;
    logic             iss_done_q, iss_done_d;   // every beat has been issued
    logic [TCW-1:0]   tx_q, tx_d;               // beats accepted downstream
    logic             rd_v_q, rd_v_d;           // read in flight
    logic [OW-1:0]    rd_data_q;
    logic [OW-1:0]    buf0_q, buf0_d, buf1_q, buf1_d;
    logic [1:0]       cnt_q, cnt_d;             // skid occupancy, 0..2

    logic             pop, issue, wr_ok, wr_in_range;
    logic [2:0]       occ;
    logic [AW-1:0]    rd_addr;

    logic [LW-1:0]    mem [PE][WMEM_DEPTH];

    assign out_v   = (cnt_q != 2'd0);
    assign out_wgt = buf0_q;
    assign busy    = (state_q == RUN);
    assign pop     = out_v & out_rdy;
    assign done    = pop & (tx_q == TCW'(TOTAL - 1));
    assign rd_addr = AW'(int'(nf_q) * SF + int'(sf_q));

    // Occupancy the skid will hold after this edge, before counting a new
    // issue: current entries, minus the pop, plus the read landing now.
    // Issuing is safe only if that leaves room for one more read.
    assign occ   = 3'(cnt_q) + 3'(rd_v_q) - 3'(pop);
    assign issue = (state_q == RUN) && !iss_done_q && (occ <= 3'd1);

    assign wr_in_range = (int'(wr_pe) < PE) && (int'(wr_addr) < WMEM_DEPTH);

`ifdef MVAU_WSTREAM_WR_GUARD_EN
    logic wr_err_q, wr_err_d;

    assign wr_ok  = wr_en && wr_in_range && !busy;
    assign wr_err = wr_err_q;

    always_comb begin
        wr_err_d = wr_err_q | (wr_en & busy);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_err_q <= 1'b0;
        else     wr_err_q <= wr_err_d;
    end
`else
    assign wr_ok  = wr_en && wr_in_range;
    assign wr_err = 1'b0;
`endif

    // NOTE: the banks and their read register carry no reset; clearing a RAM
    // is not possible in one cycle and the weights must survive a reset.
    // A same-cycle write and read of one word returns the old data because
    // both sides update with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_pe][wr_addr] <= wr_data;
        if (issue) begin
            for (int p = 0; p < PE; p++) begin
                rd_data_q[(PE-1-p)*LW +: LW] <= mem[p][rd_addr];
            end
        end
    end

    // NOTE: every signal driven here gets its default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        sf_d       = sf_q;
        nf_d       = nf_q;
        vec_d      = vec_q;
        iss_done_d = iss_done_q;
        tx_d       = tx_q;
        rd_v_d     = issue;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    sf_d       = '0;
                    nf_d       = '0;
                    vec_d      = '0;
                    iss_done_d = 1'b0;
                    tx_d       = '0;
                end
            end
            RUN: begin
                if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // sf innermost, then nf, then vec; the address wraps per vector.
        if (issue) begin
            if (sf_q == SFW'(SF - 1)) begin
                sf_d = '0;
                if (nf_q == NFW'(NF - 1)) begin
                    nf_d = '0;
                    if (vec_q == VW'(NUM_VEC - 1)) begin
                        vec_d      = '0;
                        iss_done_d = 1'b1;
                    end else begin
                        vec_d = vec_q + VW'(1);
                    end
                end else begin
                    nf_d = nf_q + NFW'(1);
                end
            end else begin
                sf_d = sf_q + SFW'(1);
            end
        end

        // Pop shifts the second entry forward; the landing read then fills
        // the first free slot.
        if (pop) begin
            tx_d   = tx_q + TCW'(1);
            buf0_d = buf1_q;
            cnt_d  = cnt_q - 2'd1;
        end
        if (rd_v_q) begin
            if (cnt_d == 2'd0) buf0_d = rd_data_q;
            else               buf1_d = rd_data_q;
            cnt_d = cnt_d + 2'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample
    // the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sf_q       <= '0;
            nf_q       <= '0;
            vec_q      <= '0;
            iss_done_q <= 1'b0;
            tx_q       <= '0;
            rd_v_q     <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sf_q       <= sf_d;
            nf_q       <= nf_d;
            vec_q      <= vec_d;
            iss_done_q <= iss_done_d;
            tx_q       <= tx_d;
            rd_v_q     <= rd_v_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
